// File: rtl/tx_gain_agc.sv
// tx_gain_agc: closed-loop automatic gain control for the transmit core.
//
// Holds the per-cycle peak magnitude from the transmit core over fixed windows
// of 2^WIN_LOG2 clocks. After each window, the peak is compared against a
// target band and the mixer gain is stepped by one (or by FAST_STEP on a
// full-scale peak), saturating at [GAIN_MIN, GAIN_MAX]. After every gain change
// the loop waits SETTLE_CYCLES clocks before it measures again.
//
// Ports:
//   clock        in   system clock, rising edge
//   reset        in   asynchronous, active-high reset
//   agc_enable   in   1 = closed loop, 0 = manual gain
//   manual_gain  in   [7:0]  gain used when disabled; seeds the loop on enable
//   target_level in   [15:0] desired window peak
//   hysteresis   in   [15:0] half-width of the acceptance band
//   interval_max in   [15:0] per-cycle peak magnitude from the transmit core
//   mixer_gain   out  [7:0]  registered gain to the transmit core
//   agc_locked   out  loop has been in band for LOCK_WINDOWS windows
//   peak_level   out  [15:0] peak of the last completed window
//   agc_state    out  [1:0]  0 IDLE, 1 SETTLE, 2 MEASURE, 3 DECIDE
module tx_gain_agc #(
    parameter int unsigned WIN_LOG2      = 10,
    parameter int unsigned SETTLE_CYCLES = 64,
    parameter int unsigned LOCK_WINDOWS  = 4,
    parameter int unsigned GAIN_MIN      = 0,
    parameter int unsigned GAIN_MAX      = 255,
    parameter int unsigned GAIN_INIT     = 64,
    parameter int unsigned FAST_STEP     = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        agc_enable,
    input  logic [7:0]  manual_gain,
    input  logic [15:0] target_level,
    input  logic [15:0] hysteresis,
    input  logic [15:0] interval_max,
    output logic [7:0]  mixer_gain,
    output logic        agc_locked,
    output logic [15:0] peak_level,
    output logic [1:0]  agc_state
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_SETTLE  = 2'd1;
    localparam logic [1:0] ST_MEASURE = 2'd2;
    localparam logic [1:0] ST_DECIDE  = 2'd3;

    localparam int unsigned SET_W  = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int unsigned LOCK_W = (LOCK_WINDOWS > 0) ? $clog2(LOCK_WINDOWS + 1) : 1;

    // Settle counter counts down to zero, so a load of N-1 gives N settle clocks.
    localparam logic [SET_W-1:0]  SETTLE_LOAD = SET_W'(SETTLE_CYCLES - 1);
    localparam logic [LOCK_W-1:0] LOCK_FULL   = LOCK_W'(LOCK_WINDOWS);
    localparam logic [7:0]        G_INIT      = 8'(GAIN_INIT);

    // Gain arithmetic is done signed and wider than the gain so that
    // under/overflow is clamped instead of wrapping.
    localparam logic signed [9:0] G_MIN  = 10'(GAIN_MIN);
    localparam logic signed [9:0] G_MAX  = 10'(GAIN_MAX);
    localparam logic signed [9:0] G_FAST = 10'(FAST_STEP);

    logic [1:0]          state_q, state_d;
    logic [7:0]          gain_q, gain_d;
    logic [SET_W-1:0]    settle_q, settle_d;
    logic [WIN_LOG2-1:0] win_q, win_d;
    logic [15:0]         peak_acc_q, peak_acc_d;
    logic [15:0]         peak_lvl_q, peak_lvl_d;
    logic [LOCK_W-1:0]   lock_q, lock_d;
    logic                locked_q;

    logic [15:0]        peak_next;
    logic [16:0]        upper_sum;
    logic [15:0]        upper;
    logic [15:0]        lower;
    logic signed [9:0]  gain_s;
    logic signed [9:0]  gain_calc;
    logic signed [9:0]  gain_clamp;
    logic [7:0]         gain_dec;
    logic               in_band;
    logic               gain_changed;

    // Running window peak including the current sample.
    assign peak_next = (interval_max > peak_acc_q) ? interval_max : peak_acc_q;

    // Acceptance band, saturated at both ends.
    assign upper_sum = {1'b0, target_level} + {1'b0, hysteresis};
    assign upper     = upper_sum[16] ? 16'hFFFF : upper_sum[15:0];
    assign lower     = (hysteresis > target_level) ? 16'h0000 : (target_level - hysteresis);

    assign gain_s = $signed({2'b00, gain_q});

    always_comb begin
        in_band   = 1'b0;
        gain_calc = gain_s;
        if (peak_lvl_q == 16'hFFFF) begin
            gain_calc = gain_s - G_FAST;
        end else if (peak_lvl_q > upper) begin
            gain_calc = gain_s - 10'sd1;
        end else if (peak_lvl_q < lower) begin
            gain_calc = gain_s + 10'sd1;
        end else begin
            in_band = 1'b1;
        end

        if (gain_calc < G_MIN) begin
            gain_clamp = G_MIN;
        end else if (gain_calc > G_MAX) begin
            gain_clamp = G_MAX;
        end else begin
            gain_clamp = gain_calc;
        end

        gain_dec     = in_band ? gain_q : 8'(gain_clamp);
        gain_changed = (gain_dec != gain_q);
    end

    always_comb begin
        state_d    = state_q;
        gain_d     = gain_q;
        settle_d   = settle_q;
        win_d      = win_q;
        peak_acc_d = peak_acc_q;
        peak_lvl_d = peak_lvl_q;
        lock_d     = lock_q;

        if (!agc_enable) begin
            // Manual mode; any partial window is simply abandoned.
            state_d = ST_IDLE;
            gain_d  = manual_gain;
            lock_d  = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d  = ST_SETTLE;
                    settle_d = SETTLE_LOAD;
                    gain_d   = manual_gain;
                    lock_d   = '0;
                end
                ST_SETTLE: begin
                    if (settle_q == '0) begin
                        state_d    = ST_MEASURE;
                        win_d      = '0;
                        peak_acc_d = '0;
                    end else begin
                        settle_d = settle_q - SET_W'(1);
                    end
                end
                ST_MEASURE: begin
                    peak_acc_d = peak_next;
                    win_d      = win_q + WIN_LOG2'(1);
                    if (&win_q) begin
                        state_d    = ST_DECIDE;
                        peak_lvl_d = peak_next;
                    end
                end
                ST_DECIDE: begin
                    gain_d = gain_dec;
                    if (gain_changed) begin
                        lock_d   = '0;
                        state_d  = ST_SETTLE;
                        settle_d = SETTLE_LOAD;
                    end else begin
                        state_d    = ST_MEASURE;
                        win_d      = '0;
                        peak_acc_d = '0;
                        if (in_band) begin
                            lock_d = (lock_q == LOCK_FULL) ? lock_q : (lock_q + LOCK_W'(1));
                        end else begin
                            // Out of band but pinned at a gain limit.
                            lock_d = '0;
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            gain_q     <= G_INIT;
            settle_q   <= '0;
            win_q      <= '0;
            peak_acc_q <= '0;
            peak_lvl_q <= '0;
            lock_q     <= '0;
            locked_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            gain_q     <= gain_d;
            settle_q   <= settle_d;
            win_q      <= win_d;
            peak_acc_q <= peak_acc_d;
            peak_lvl_q <= peak_lvl_d;
            lock_q     <= lock_d;
            // Follows the next lock count so it drops on the clearing edge.
            locked_q   <= (lock_d == LOCK_FULL);
        end
    end

    assign mixer_gain = gain_q;
    assign agc_locked = locked_q;
    assign peak_level = peak_lvl_q;
    assign agc_state  = state_q;

endmodule
